// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath sizing, writeback select encoding and
// the forwarding record handed from WB back to the EX forwarding unit.
package pipe_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int REG_CNT = 2 ** ADDR_W;
  localparam int RET_W   = 16;

  // ALUMEMSIG meaning as produced by the MEM stage
  localparam logic WBSEL_ALU = 1'b0;
  localparam logic WBSEL_MEM = 1'b1;

  localparam logic [DATA_W-1:0] REG_RST = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/writeback_reg_file.sv
// Architectural register file: one write port, two asynchronous read ports,
// R0 hardwired to zero. Same-cycle write-through is enabled by WB_BYPASS_EN.
module reg_file
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // we is already qualified to exclude R0, so regs[0] keeps its reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= REG_RST;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = REG_RST;
    if (raddr_a != '0) begin
`ifdef WB_BYPASS_EN
      if (we && (waddr == raddr_a)) begin
        rdata_a = wdata;
      end else begin
        rdata_a = regs[raddr_a];
      end
`else
      rdata_a = regs[raddr_a];
`endif
    end
  end

  always_comb begin
    rdata_b = REG_RST;
    if (raddr_b != '0) begin
`ifdef WB_BYPASS_EN
      if (we && (waddr == raddr_b)) begin
        rdata_b = wdata;
      end else begin
        rdata_b = regs[raddr_b];
      end
`else
      rdata_b = regs[raddr_b];
`endif
    end
  end

endmodule

// File: rtl/writeback.sv
// WB stage: selects load/ALU data, writes the register file, publishes the
// last-writeback forwarding record and counts retired instructions. Option: WB_BYPASS_EN.
module writeback
  import pipe_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              WBVALID,
  input  logic              WBEN,
  input  logic              ALUMEMSIG,
  input  logic [DATA_W-1:0] MEMDATA,
  input  logic [DATA_W-1:0] ALUDATA,
  input  logic [ADDR_W-1:0] WBDEST,
  input  logic [ADDR_W-1:0] RADDRA,
  input  logic [ADDR_W-1:0] RADDRB,
  output logic [DATA_W-1:0] RDATAA,
  output logic [DATA_W-1:0] RDATAB,
  output logic [DATA_W-1:0] WBDATA,
  output logic              LASTWBVALID,
  output logic [ADDR_W-1:0] LASTWBDEST,
  output logic [DATA_W-1:0] LASTWBDATA,
  output logic [RET_W-1:0]  RETIRED
);

  logic [DATA_W-1:0] wb_sel;
  logic              wr;
  wb_rec_t           last_q;
  logic [RET_W-1:0]  retired_q;

  assign wb_sel = (ALUMEMSIG == WBSEL_MEM) ? MEMDATA : ALUDATA;
  assign wr     = WBVALID & WBEN & (WBDEST != '0);

  reg_file u_reg_file (
    .clk     (CLOCK_50),
    .rst     (RESET),
    .we      (wr),
    .waddr   (WBDEST),
    .wdata   (wb_sel),
    .raddr_a (RADDRA),
    .raddr_b (RADDRB),
    .rdata_a (RDATAA),
    .rdata_b (RDATAB)
  );

  // Record is captured every cycle; consumers qualify with the valid bit
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      last_q    <= '0;
      retired_q <= '0;
    end else begin
      last_q.valid <= wr;
      last_q.dest  <= WBDEST;
      last_q.data  <= wb_sel;
      if (WBVALID) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign WBDATA      = wb_sel;
  assign LASTWBVALID = last_q.valid;
  assign LASTWBDEST  = last_q.dest;
  assign LASTWBDATA  = last_q.data;
  assign RETIRED     = retired_q;

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed steps plus randomized traffic checked against
// an array-based architectural model of the register file and retire count.
module tb_writeback;

  logic        CLOCK_50 = 1'b0;
  logic        RESET, WBVALID, WBEN, ALUMEMSIG;
  logic [15:0] MEMDATA, ALUDATA;
  logic [2:0]  WBDEST, RADDRA, RADDRB;
  logic [15:0] RDATAA, RDATAB, WBDATA;
  logic        LASTWBVALID;
  logic [2:0]  LASTWBDEST;
  logic [15:0] LASTWBDATA;
  logic [15:0] RETIRED;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_regs [8];
  logic        m_lv;
  logic [2:0]  m_ld;
  logic [15:0] m_ldata;
  logic [15:0] m_ret;
  logic [15:0] obs_ra, obs_rb;
  logic [15:0] ret_save;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #10 CLOCK_50 = ~CLOCK_50;

  writeback dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .WBVALID     (WBVALID),
    .WBEN        (WBEN),
    .ALUMEMSIG   (ALUMEMSIG),
    .MEMDATA     (MEMDATA),
    .ALUDATA     (ALUDATA),
    .WBDEST      (WBDEST),
    .RADDRA      (RADDRA),
    .RADDRB      (RADDRB),
    .RDATAA      (RDATAA),
    .RDATAB      (RDATAB),
    .WBDATA      (WBDATA),
    .LASTWBVALID (LASTWBVALID),
    .LASTWBDEST  (LASTWBDEST),
    .LASTWBDATA  (LASTWBDATA),
    .RETIRED     (RETIRED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] ra, input logic wr,
                                           input logic [2:0] dest, input logic [15:0] wd);
    if (ra == 3'd0) return 16'h0000;
    if (BYPASS && wr && ra == dest) return wd;
    return m_regs[ra];
  endfunction

  // One clock: drive after negedge, check combinational outputs, advance model
  // at posedge, then check the registered outputs.
  task automatic step(input logic rst, input logic valid, input logic en, input logic sel,
                      input logic [15:0] md, input logic [15:0] ad,
                      input logic [2:0] dest, input logic [2:0] ra, input logic [2:0] rb);
    logic        wr;
    logic [15:0] wd;
    @(negedge CLOCK_50);
    RESET = rst; WBVALID = valid; WBEN = en; ALUMEMSIG = sel;
    MEMDATA = md; ALUDATA = ad; WBDEST = dest; RADDRA = ra; RADDRB = rb;
    #1;
    wd = sel ? md : ad;
    wr = valid && en && (dest != 3'd0);
    obs_ra = RDATAA;
    obs_rb = RDATAB;
    chk("wbdata", WBDATA, wd);
    chk("rdataa", RDATAA, exp_read(ra, wr, dest, wd));
    chk("rdatab", RDATAB, exp_read(rb, wr, dest, wd));
    @(posedge CLOCK_50);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_lv = 1'b0; m_ld = 3'd0; m_ldata = 16'h0000; m_ret = 16'h0000;
    end else begin
      if (wr) m_regs[dest] = wd;
      m_lv = wr; m_ld = dest; m_ldata = wd;
      if (valid) m_ret = m_ret + 16'd1;
    end
    #1;
    chk("lastwbvalid", LASTWBVALID, m_lv);
    chk("lastwbdest", LASTWBDEST, m_ld);
    chk("lastwbdata", LASTWBDATA, m_ldata);
    chk("retired", RETIRED, m_ret);
  endtask

  task automatic rand_step(input bit allow_rst, input bit force_valid);
    step(allow_rst && ($urandom_range(0, 31) == 0),
         force_valid ? 1'b1 : 1'($urandom_range(0, 3) != 0),
         1'($urandom_range(0, 3) != 0), 1'($urandom),
         16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
  endtask

  initial begin
    RESET = 1'b1; WBVALID = 1'b0; WBEN = 1'b0; ALUMEMSIG = 1'b0;
    MEMDATA = '0; ALUDATA = '0; WBDEST = '0; RADDRA = '0; RADDRB = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_lv = 1'b0; m_ld = 3'd0; m_ldata = 16'h0000; m_ret = 16'h0000;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // preload every register non-zero, then reset for one cycle
    for (int i = 1; i < 8; i++) step(0, 1, 1, 0, 0, 16'h1000 + 16'(i), 3'(i), 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_retired", RETIRED, 16'h0000);
    chk("rst_lastvalid", LASTWBVALID, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i));
      chk("rst_read", obs_ra, 16'h0000);
    end

    // memory-data select
    step(0, 1, 1, 1, 16'hBEEF, 16'h1234, 3, 0, 0);
    chk("mem_lastdest", LASTWBDEST, 3'd3);
    chk("mem_lastdata", LASTWBDATA, 16'hBEEF);
    step(0, 0, 0, 0, 0, 0, 0, 3, 3);
    chk("mem_read", obs_ra, 16'hBEEF);

    // ALU-data select
    step(0, 1, 1, 0, 16'hBEEF, 16'h1234, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 3, 0);
    chk("alu_read", obs_ra, 16'h1234);

    // R0 write is dropped but still retires
    ret_save = RETIRED;
    step(0, 1, 1, 0, 0, 16'hFFFF, 0, 0, 0);
    chk("r0_lastvalid", LASTWBVALID, 1'b0);
    chk("r0_retired", RETIRED, ret_save + 16'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_read", obs_ra, 16'h0000);

    // same-cycle read of the register being written
    step(0, 1, 1, 0, 0, 16'h0011, 5, 0, 0);
    step(0, 1, 1, 0, 0, 16'h00A5, 5, 0, 5);
    chk("same_cycle_rb", obs_rb, BYPASS ? 16'h00A5 : 16'h0011);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5);
    chk("next_cycle_rb", obs_rb, 16'h00A5);

    // store/NOP: counts but writes nothing
    ret_save = RETIRED;
    step(0, 1, 0, 0, 0, 16'hDEAD, 5, 0, 0);
    chk("store_retired", RETIRED, ret_save + 16'd1);
    chk("store_lastvalid", LASTWBVALID, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 5);
    chk("store_read", obs_ra, 16'h00A5);

    // reset together with a valid write
    step(0, 1, 1, 0, 0, 16'h1111, 2, 0, 0);
    step(1, 1, 1, 0, 0, 16'h7777, 2, 0, 0);
    chk("rstmid_retired", RETIRED, 16'h0000);
    chk("rstmid_lastvalid", LASTWBVALID, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 2, 2);
    chk("rstmid_read", obs_ra, 16'h0000);

    for (int i = 0; i < 400; i++) rand_step(1'b1, 1'b0);

    // counter wrap
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) rand_step(1'b0, 1'b1);
    chk("wrap_ffff", RETIRED, 16'hFFFF);
    rand_step(1'b0, 1'b1);
    chk("wrap_zero", RETIRED, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
